bram_delay_prog_ctrl: RTL and testbench
=======================================

Name: bram_delay_prog_ctrl

Overview:
- Runtime-programmable delay line: sequences write/read addresses of a simple-dual-port BRAM so `dout` is `din` delayed by a software-set number of `ce` cycles.
- Replaces fixed-delay BRAM delays where the delay is set over a config handshake.
- Sits between a register/config interface and the streaming datapath.
- Tracks fill state and flags when output samples are genuine.

Parameters:
- WIDTH, 32, data width in bits.
- MAX_DELAY, 1024, largest programmable delay in ce cycles.
- LATENCY, 2, BRAM read latency; legal values 1 or 2.
- ADDR_BITS, `log2(MAX_DELAY), RAM address width (derived localparam).
- RESET_DELAY, 16, delay used after reset until first config.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- ce  in  1  clock enable; all pointers, counters and the RAM pipeline advance only when ce=1.
- din  in  WIDTH  data input.
- dout  out  WIDTH  delayed data output.
- dout_valid  out  1  dout holds a sample written after the last accepted config.
- cfg_delay  in  ADDR_BITS+1  requested delay D.
- cfg_valid  in  1  config request.
- cfg_ready  out  1  config accept; a transfer happens when cfg_valid & cfg_ready.
- cfg_err  out  1  one-cycle pulse: the accepted delay was out of range and clamped.
- cur_delay  out  ADDR_BITS+1  delay currently in effect.

Behaviour:
- Interface (already decided): single clock `clk`; reset `rst` is synchronous and active-high.
- Reset values:
  - wr_addr=0, fill_cnt=0, state=FILL, cur_delay=RESET_DELAY.
  - dout_valid=0, cfg_ready=0, cfg_err=0.
  - dout=0 from the RAM output register.
- States:
  - FILL: fill_cnt counts ce cycles since entry.
  - RUN: normal operation.
- Transitions:
  - FILL -> RUN on the ce cycle where fill_cnt == cur_delay-1. dout_valid rises in that cycle's next clock.
  - RUN -> FILL on config acceptance; fill_cnt is cleared and dout_valid drops in the next clock.
- Handshake:
  - cfg_ready=1 only in RUN, and deasserted in the cycle after acceptance.
  - cfg_valid may be held; no acceptance while in FILL.
  - cfg_valid during rst is ignored.
- Clamping:
  - D < LATENCY+1 is clamped to LATENCY+1.
  - D > MAX_DELAY is clamped to MAX_DELAY.
  - Clamping pulses cfg_err for one clock in the cycle after acceptance.
  - cur_delay updates in the cycle after acceptance.
- Addressing:
  - wr_addr increments by 1 per ce cycle, modulo 2^ADDR_BITS.
  - rd_addr = wr_addr - (cur_delay - LATENCY), computed in ADDR_BITS-wide unsigned arithmetic so wrap-around is natural.
  - The RAM write enable is ce.
  - The RAM read-enable and output-register enables are ce.
- Latency: in RUN, the dout produced on the k-th ce cycle equals the din presented D ce cycles earlier, exactly.
- ce low: nothing advances; dout, dout_valid and fill_cnt hold. cfg acceptance is still allowed.
- Delay change mid-stream: wr_addr is not disturbed, and RAM contents are not cleared. Samples during FILL may be stale and are marked invalid.
- Simultaneous cfg acceptance and FILL completion: cannot occur, since cfg_ready=0 in FILL.
- Reset mid-operation: returns to the reset values above, including cur_delay=RESET_DELAY.

Optional Feature:
- Macro BRAM_DELAY_PROG_ZERO_INVALID_EN.
- Defined: dout is forced to 0 whenever dout_valid=0 (registered gating, no extra latency). Downstream accumulators see zeros during FILL.
- Undefined: dout is the raw RAM output at all times; consumers must qualify with dout_valid.

Decomposition:
- Shared package/include holds:
  - the `log2 macro (existing math include);
  - state encoding constants FILL=1'b0, RUN=1'b1;
  - the clamp-bound localparams.
- One sub-module: sdp_ram with parameters A_WIDTH, D_WIDTH, LATENCY.
  - Write port: clk, we, waddr, din.
  - Read port: re, raddr, dout; latency 1 or 2 registers, each gated by re.
- Controller logic stays in bram_delay_prog_ctrl.

Test Plan:
- Reset, ce=1, din=ramp 1,2,3… -> dout_valid rises after 16 ce cycles; dout then equals din-16 on every cycle.
- In RUN, cfg_delay=100, cfg_valid one cycle -> cfg_ready drops, cur_delay=100, dout_valid low for 100 ce cycles, then dout=din-100 and cfg_ready=1.
- cfg_delay=1 with LATENCY=2 -> clamped to 3, cfg_err pulses once; cfg_delay=2000 -> clamped to 1024, cfg_err pulses, dout=din-1024 after fill.
- cfg_delay=1024 with a ramp longer than 2048 samples -> correct across multiple address wraps; no off-by-one at wr_addr=1023->0.
- ce toggled pseudo-randomly (50%), D=37 -> dout sequence equals din sequence shifted by 37 ce-qualified samples; outputs hold while ce=0.
- rst asserted mid-FILL after cfg 200 -> next clock: dout_valid=0, cur_delay=16, cfg_ready=0; valid returns 16 ce cycles after rst release.
- Run the delay-change scenario (cfg_delay=100) with BRAM_DELAY_PROG_ZERO_INVALID_EN defined -> dout=0 throughout FILL.

Source files
------------

// File: rtl/bram_delay_prog_ctrl_pkg.sv
// Shared definitions for the programmable BRAM delay line: the log2 helper
// macro, FSM state encoding and the clamp-bound helpers.
`ifndef BRAM_DELAY_PROG_CTRL_PKG_SV
`define BRAM_DELAY_PROG_CTRL_PKG_SV

`ifndef LOG2
`define LOG2(x) $clog2(x)
`endif

package bram_delay_prog_ctrl_pkg;

    // FILL: waiting for the RAM to hold a full delay's worth of fresh samples.
    // RUN:  dout is genuine and a new delay may be requested.
    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Smallest delay keeps at least one slot between write and read address.
    localparam int LAT_MARGIN = 1;

    function automatic int min_delay(input int latency);
        return latency + LAT_MARGIN;
    endfunction

endpackage

`endif

// File: rtl/bram_delay_prog_ctrl_if.sv
// Configuration port of the programmable delay line.
//
// Handshake: a transfer happens on a rising clk edge where cfg_valid and
// cfg_ready are both 1. The master may hold cfg_valid with a stable
// cfg_delay for as long as it likes; the slave drops cfg_ready in the cycle
// after a transfer and raises it again only once the new delay is filled.
interface bram_delay_prog_ctrl_if #(
    parameter int ADDR_BITS = 10
);
    logic [ADDR_BITS:0] cfg_delay;
    logic               cfg_valid;
    logic               cfg_ready;
    logic               cfg_err;
    logic [ADDR_BITS:0] cur_delay;

    modport master (
        output cfg_delay, cfg_valid,
        input  cfg_ready, cfg_err, cur_delay
    );

    modport slave (
        input  cfg_delay, cfg_valid,
        output cfg_ready, cfg_err, cur_delay
    );
endinterface

// File: rtl/bram_delay_prog_ctrl_sdp_ram.sv
// Simple dual-port RAM with one or two read registers, all gated by re.
// The read registers carry a synchronous reset so dout starts at zero.
module sdp_ram #(
    parameter int A_WIDTH = 10,
    parameter int D_WIDTH = 32,
    parameter int LATENCY = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               we,
    input  logic [A_WIDTH-1:0] waddr,
    input  logic [D_WIDTH-1:0] din,
    input  logic               re,
    input  logic [A_WIDTH-1:0] raddr,
    output logic [D_WIDTH-1:0] dout
);
    logic [D_WIDTH-1:0] mem [2**A_WIDTH];
    logic [D_WIDTH-1:0] rd_q;

    // Write port.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= din;
    end

    // First read register (array output register).
    always_ff @(posedge clk) begin
        if (rst)     rd_q <= '0;
        else if (re) rd_q <= mem[raddr];
    end

    generate
        if (LATENCY == 2) begin : g_lat2
            logic [D_WIDTH-1:0] out_q;
            // Second (output) register for the two-cycle read path.
            always_ff @(posedge clk) begin
                if (rst)     out_q <= '0;
                else if (re) out_q <= rd_q;
            end
            assign dout = out_q;
        end else begin : g_lat1
            assign dout = rd_q;
        end
    endgenerate
endmodule

// File: rtl/bram_delay_prog_ctrl.sv
// Runtime-programmable delay line built on a simple dual-port RAM.
// dout follows din by cur_delay ce cycles; dout_valid marks samples written
// after the last accepted configuration.
// Optional: BRAM_DELAY_PROG_ZERO_INVALID_EN forces dout to 0 while dout_valid=0.
module bram_delay_prog_ctrl
    import bram_delay_prog_ctrl_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MAX_DELAY   = 1024,
    parameter int LATENCY     = 2,
    parameter int RESET_DELAY = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ce,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   dout_valid,
    bram_delay_prog_ctrl_if.slave  cfg,
    output state_t                 state_dbg
);
    localparam int ADDR_BITS = `LOG2(MAX_DELAY);
    localparam int DW        = ADDR_BITS + 1;
    localparam logic [DW-1:0]        MIN_D = DW'(min_delay(LATENCY));
    localparam logic [DW-1:0]        MAX_D = DW'(MAX_DELAY);
    localparam logic [DW-1:0]        RST_D = DW'(RESET_DELAY);
    localparam logic [DW-1:0]        ONE_D = DW'(1);
    localparam logic [ADDR_BITS-1:0] LAT_A = ADDR_BITS'(LATENCY);

    state_t                state;
    logic [ADDR_BITS-1:0]  wr_addr;
    logic [ADDR_BITS-1:0]  rd_addr;
    logic [DW-1:0]         fill_cnt;
    logic [DW-1:0]         cur_delay;
    logic [DW-1:0]         clamped;
    logic                  clamp_hit;
    logic                  cfg_ready_q;
    logic                  cfg_err_q;
    logic                  accept;
    logic [WIDTH-1:0]      ram_q;

    assign accept = cfg.cfg_valid & cfg_ready_q;

    // Clamp the requested delay into the legal range.
    always_comb begin
        clamped   = cfg.cfg_delay;
        clamp_hit = 1'b0;
        if (cfg.cfg_delay < MIN_D) begin
            clamped   = MIN_D;
            clamp_hit = 1'b1;
        end else if (cfg.cfg_delay > MAX_D) begin
            clamped   = MAX_D;
            clamp_hit = 1'b1;
        end
    end

    // Read trails write so the sample leaving the read pipeline is exactly
    // cur_delay ce cycles old; modular subtraction handles the wrap.
    assign rd_addr = wr_addr - (cur_delay[ADDR_BITS-1:0] - LAT_A);

    // Write pointer runs freely; a delay change never disturbs it.
    always_ff @(posedge clk) begin
        if (rst)     wr_addr <= '0;
        else if (ce) wr_addr <= wr_addr + 1'b1;
    end

    // Fill/run controller with registered handshake and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FILL;
            fill_cnt    <= '0;
            cur_delay   <= RST_D;
            dout_valid  <= 1'b0;
            cfg_ready_q <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            cfg_err_q <= 1'b0;
            case (state)
                FILL: begin
                    if (ce) begin
                        if (fill_cnt == cur_delay - ONE_D) begin
                            state       <= RUN;
                            dout_valid  <= 1'b1;
                            cfg_ready_q <= 1'b1;
                        end else begin
                            fill_cnt <= fill_cnt + ONE_D;
                        end
                    end
                end
                RUN: begin
                    if (accept) begin
                        state       <= FILL;
                        fill_cnt    <= '0;
                        cur_delay   <= clamped;
                        cfg_err_q   <= clamp_hit;
                        dout_valid  <= 1'b0;
                        cfg_ready_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    sdp_ram #(
        .A_WIDTH (ADDR_BITS),
        .D_WIDTH (WIDTH),
        .LATENCY (LATENCY)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (ce),
        .waddr (wr_addr),
        .din   (din),
        .re    (ce),
        .raddr (rd_addr),
        .dout  (ram_q)
    );

`ifdef BRAM_DELAY_PROG_ZERO_INVALID_EN
    // Both operands are registers, so the gating adds no latency.
    assign dout = dout_valid ? ram_q : '0;
`else
    assign dout = ram_q;
`endif

    assign cfg.cfg_ready = cfg_ready_q;
    assign cfg.cfg_err   = cfg_err_q;
    assign cfg.cur_delay = cur_delay;
    assign state_dbg     = state;
endmodule

// File: tb/tb_bram_delay_prog_ctrl.sv
// Bench for bram_delay_prog_ctrl: table of configuration cases plus
// hand-written corner sequences, scored against a FIFO-style delay model.
module tb_bram_delay_prog_ctrl;
    import bram_delay_prog_ctrl_pkg::*;

    localparam int WIDTH       = 32;
    localparam int MAX_DELAY   = 1024;
    localparam int LATENCY     = 2;
    localparam int RESET_DELAY = 16;
    localparam int AB          = 10;
    localparam int DW          = AB + 1;

    // ---------------- clock / reset / DUT ----------------
    logic             clk = 1'b0;
    logic             rst;
    logic             ce;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    state_t           state_dbg;

    always #5 clk = ~clk;

    bram_delay_prog_ctrl_if #(.ADDR_BITS(AB)) cfg ();

    bram_delay_prog_ctrl #(
        .WIDTH       (WIDTH),
        .MAX_DELAY   (MAX_DELAY),
        .LATENCY     (LATENCY),
        .RESET_DELAY (RESET_DELAY)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ce         (ce),
        .din        (din),
        .dout       (dout),
        .dout_valid (dout_valid),
        .cfg        (cfg),
        .state_dbg  (state_dbg)
    );

    // ---------------- reference model / scoreboard ----------------
    // exp_q holds the samples written since the last config (or reset),
    // capped at the current delay; the output is genuine once it is full,
    // and the genuine output is its oldest entry.
    logic [WIDTH-1:0] exp_q[$];
    int               exp_d;
    logic             exp_valid;
    logic             exp_err;
    int               errors = 0;
    int               checks = 0;
    logic [WIDTH-1:0] ramp = 1;

    task automatic check(input string name, input logic [WIDTH-1:0] act,
                         input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int clamp(input int d);
        if (d < LATENCY + 1) return LATENCY + 1;
        if (d > MAX_DELAY)   return MAX_DELAY;
        return d;
    endfunction

    // ---------------- driver ----------------
    task automatic step(input logic r, input logic c, input logic [WIDTH-1:0] d_in,
                        input logic cv, input int cd);
        rst           = r;
        ce            = c;
        din           = d_in;
        cfg.cfg_valid = cv;
        cfg.cfg_delay = DW'(cd);
        @(posedge clk);
        if (r) begin
            exp_q.delete();
            exp_d     = RESET_DELAY;
            exp_valid = 1'b0;
            exp_err   = 1'b0;
        end else begin
            exp_err = 1'b0;
            if (cv && exp_valid) begin
                exp_err = (clamp(cd) != cd);
                exp_d   = clamp(cd);
                exp_q.delete();
            end else if (c) begin
                exp_q.push_back(d_in);
                if (exp_q.size() > exp_d) void'(exp_q.pop_front());
            end
            exp_valid = (exp_q.size() == exp_d);
        end
        #1;
        check("dout_valid", dout_valid, exp_valid);
        check("cfg_ready", cfg.cfg_ready, exp_valid);
        check("cur_delay", cfg.cur_delay, exp_d);
        check("cfg_err", cfg.cfg_err, exp_err);
        if (exp_valid) check("dout", dout, exp_q[0]);
`ifdef BRAM_DELAY_PROG_ZERO_INVALID_EN
        else check("dout_zero_invalid", dout, '0);
`endif
    endtask

    task automatic run(input int n, input logic rand_ce);
        for (int i = 0; i < n; i++) begin
            if (rand_ce) step(1'b0, 1'($urandom_range(0, 1)), $urandom, 1'b0, 0);
            else begin
                step(1'b0, 1'b1, ramp, 1'b0, 0);
                ramp++;
            end
        end
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 3000 && !exp_valid; i++) begin
            step(1'b0, 1'b1, ramp, 1'b0, 0);
            ramp++;
        end
        check("wait_ready", cfg.cfg_ready, 1'b1);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int   delay;
        int   exp_cur;
        logic exp_err;
        int   run_len;
        logic rand_ce;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{100,  100,  1'b0, 150,  1'b0};
        vecs[1] = '{1,    3,    1'b1, 40,   1'b0};
        vecs[2] = '{3,    3,    1'b0, 40,   1'b0};
        vecs[3] = '{2000, 1024, 1'b1, 1100, 1'b0};
        vecs[4] = '{1024, 1024, 1'b0, 2300, 1'b0};
        vecs[5] = '{37,   37,   1'b0, 300,  1'b1};
        vecs[6] = '{1025, 1024, 1'b1, 1040, 1'b0};

        rst = 1'b1; ce = 1'b0; din = '0;
        cfg.cfg_valid = 1'b0; cfg.cfg_delay = '0;

        // Reset with cfg_valid held high: the request must be ignored.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, ramp, 1'b1, 5);
        check("reset_dout", dout, '0);
        check("reset_cur_delay", cfg.cur_delay, RESET_DELAY);

        // Table: each entry is one accepted config followed by streaming.
        foreach (vecs[i]) begin
            wait_ready();
            step(1'b0, 1'b1, ramp, 1'b1, vecs[i].delay);
            ramp++;
            check("tbl_cur_delay", cfg.cur_delay, vecs[i].exp_cur);
            check("tbl_cfg_err", cfg.cfg_err, vecs[i].exp_err);
            check("tbl_ready_drop", cfg.cfg_ready, 1'b0);
            run(vecs[i].run_len, vecs[i].rand_ce);
        end

        // cfg_valid held through FILL with a different value: no re-accept.
        wait_ready();
        step(1'b0, 1'b1, ramp, 1'b1, 50);
        ramp++;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, ramp, 1'b1, 60);
            ramp++;
        end
        check("held_valid_cur", cfg.cur_delay, 50);
        run(70, 1'b0);

        // Acceptance while ce is low, then sparse ce.
        wait_ready();
        step(1'b0, 1'b0, ramp, 1'b1, 20);
        check("ce_low_accept_cur", cfg.cur_delay, 20);
        run(80, 1'b1);

        // Reset in the middle of a fill.
        wait_ready();
        step(1'b0, 1'b1, ramp, 1'b1, 200);
        ramp++;
        run(50, 1'b0);
        step(1'b1, 1'b1, ramp, 1'b1, 200);
        check("midfill_rst_dout", dout, '0);
        check("midfill_rst_valid", dout_valid, 1'b0);
        check("midfill_rst_cur", cfg.cur_delay, RESET_DELAY);
        check("midfill_rst_ready", cfg.cfg_ready, 1'b0);
        run(15, 1'b0);
        check("refill_not_yet", dout_valid, 1'b0);
        run(1, 1'b0);
        check("refill_after_16", dout_valid, 1'b1);
        run(20, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
